// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the display-counter control sequencer:
// FSM state encoding and the debounce counter width helper.
// Optional feature macro: CTRL_CLR_IN_RUN_EN (used by counter_ctrl_fsm).
package counter_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } ctrl_state_e;

  // Counter width able to hold DEBOUNCE_CYCLES-1 (cycles >= 2).
  function automatic int DBC_W(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/counter_ctrl_fsm_btn_debounce.sv
// Per-button front end: 2-FF synchroniser, stability counter that accepts
// a new level after DEBOUNCE_CYCLES consecutive differing samples, and a
// registered one-cycle pulse on each accepted rising edge (press).
module btn_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse
);

  localparam int CW = DBC_W(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          press_q;

  // Stability counter: count while the synchronised input disagrees with the
  // accepted level; flip the accepted level once the count reaches its max.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = ~level_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser, debounce state and rising-edge pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign level       = level_q;
  assign press_pulse = press_q;

endmodule

// File: rtl/counter_ctrl_fsm.sv
// Run/stop/clear/direction sequencer for the 0..9999 display counter.
// Three debounced buttons feed a Moore FSM plus a direction toggle; all
// outputs are registered. Optional macro CTRL_CLR_IN_RUN_EN lets a clear
// press in ST_RUN emit a clr pulse without stopping the counter.
module counter_ctrl_fsm
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_run,
  input  logic               btn_clr,
  input  logic               btn_dir,
  output logic               run_en,
  output logic               clr,
  output logic               dir_down,
  output logic [STATE_W-1:0] state
);

  logic       run_ev, clr_ev, dir_ev;
  logic [2:0] btn_level_unused;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk(clk), .rst(rst), .btn_raw(btn_run),
    .level(btn_level_unused[0]), .press_pulse(run_ev)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk(clk), .rst(rst), .btn_raw(btn_clr),
    .level(btn_level_unused[1]), .press_pulse(clr_ev)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir (
    .clk(clk), .rst(rst), .btn_raw(btn_dir),
    .level(btn_level_unused[2]), .press_pulse(dir_ev)
  );

  ctrl_state_e state_q, state_d;
  logic        clr_d, clr_q;
  logic        run_en_q;
  logic        dir_q;

  // Next-state and clear-request logic; clear beats run when both arrive in
  // ST_STOP, and anything arriving during ST_CLEAR is dropped.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (clr_ev)      state_d = ST_CLEAR;
        else if (run_ev) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (run_ev) state_d = ST_STOP;
`ifdef CTRL_CLR_IN_RUN_EN
        if (clr_ev) clr_d = 1'b1;
`endif
      end
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
    if (state_d == ST_CLEAR) clr_d = 1'b1;
  end

  // State and registered outputs; direction toggles on every dir press
  // regardless of what the FSM does in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_STOP;
      run_en_q <= 1'b0;
      clr_q    <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_en_q <= (state_d == ST_RUN);
      clr_q    <= clr_d;
      dir_q    <= dir_q ^ dir_ev;
    end
  end

  assign run_en   = run_en_q;
  assign clr      = clr_q;
  assign dir_down = dir_q;
  assign state    = state_q;

endmodule

// File: tb/tb_counter_ctrl_fsm.sv
// Directed bench for counter_ctrl_fsm with DEBOUNCE_CYCLES=4.
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_counter_ctrl_fsm;

  localparam int DBC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_run, btn_clr, btn_dir;
  logic       run_en, clr, dir_down;
  logic [1:0] state;

  int n_chk  = 0;
  int n_pass = 0;
  int clr_cnt = 0;
  int run_tog = 0;
  logic run_prev = 1'b0;
  logic [0:0] exp_q[$];

  counter_ctrl_fsm #(.DEBOUNCE_CYCLES(DBC)) dut (
    .clk(clk), .rst(rst),
    .btn_run(btn_run), .btn_clr(btn_clr), .btn_dir(btn_dir),
    .run_en(run_en), .clr(clr), .dir_down(dir_down), .state(state)
  );

  // clock
  always #5 clk = ~clk;

  // observers: cycles with clr high, and number of run_en transitions
  always @(posedge clk) begin
    if (clr === 1'b1) clr_cnt++;
    if (run_en !== run_prev) run_tog++;
    run_prev = run_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0=run 1=clr 2=dir 3=run+clr
  task automatic press(input int which, input int hold);
    if (which == 0 || which == 3) btn_run = 1'b1;
    if (which == 1 || which == 3) btn_clr = 1'b1;
    if (which == 2)               btn_dir = 1'b1;
    tick(hold);
    btn_run = 1'b0;
    btn_clr = 1'b0;
    btn_dir = 1'b0;
    tick(12);
  endtask

  task automatic check_dir(input string tag);
    logic [0:0] e;
    e = exp_q.pop_front();
    check(tag, {31'd0, dir_down}, {31'd0, e});
  endtask

  initial begin
    int tog0, clr0;
    rst = 1'b1; btn_run = 1'b0; btn_clr = 1'b0; btn_dir = 1'b0;
    tick(3);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_run_en", {31'd0, run_en}, 32'd0);
    rst = 1'b0;
    tick(2);

    // run press: latency and single transition
    tog0 = run_tog;
    btn_run = 1'b1;
    tick(7);
    check("run_lat_pre", {31'd0, run_en}, 32'd0);
    tick(1);
    check("run_lat_post", {31'd0, run_en}, 32'd1);
    check("run_state", {30'd0, state}, 32'd1);
    tick(2);
    btn_run = 1'b0;
    tick(12);
    check("run_one_tog", run_tog - tog0, 32'd1);

    // glitch and bounce: no effect
    tog0 = run_tog;
    btn_run = 1'b1; tick(3); btn_run = 1'b0; tick(8);
    btn_run = 1'b1; tick(2); btn_run = 1'b0; tick(1);
    btn_run = 1'b1; tick(2); btn_run = 1'b0; tick(10);
    check("glitch_run_en", {31'd0, run_en}, 32'd1);
    check("glitch_tog", run_tog - tog0, 32'd0);

    // clear press in RUN
    clr0 = clr_cnt;
    press(1, 6);
`ifdef CTRL_CLR_IN_RUN_EN
    check("clr_in_run_cnt", clr_cnt - clr0, 32'd1);
`else
    check("clr_in_run_cnt", clr_cnt - clr0, 32'd0);
`endif
    check("clr_in_run_tog", run_tog - tog0, 32'd0);
    check("clr_in_run_state", {30'd0, state}, 32'd1);

    // second run press stops
    press(0, 6);
    check("stop_run_en", {31'd0, run_en}, 32'd0);
    check("stop_tog", run_tog - tog0, 32'd1);

    // clear from STOP: 0 -> 2 -> 0, clr exactly one cycle
    clr0 = clr_cnt;
    btn_clr = 1'b1;
    tick(8);
    check("clr_state_2", {30'd0, state}, 32'd2);
    check("clr_high", {31'd0, clr}, 32'd1);
    tick(1);
    check("clr_state_0", {30'd0, state}, 32'd0);
    check("clr_low", {31'd0, clr}, 32'd0);
    btn_clr = 1'b0;
    tick(12);
    check("clr_width", clr_cnt - clr0, 32'd1);

    // run + clr together in STOP: clear wins
    clr0 = clr_cnt;
    tog0 = run_tog;
    press(3, 6);
    check("both_clr_cnt", clr_cnt - clr0, 32'd1);
    check("both_run_en", {31'd0, run_en}, 32'd0);
    check("both_tog", run_tog - tog0, 32'd0);
    check("both_state", {30'd0, state}, 32'd0);

    // direction toggles in STOP, RUN, CLEAR
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    press(2, 6);
    check_dir("dir_stop");
    check("dir_stop_state", {30'd0, state}, 32'd0);
    press(0, 6);
    press(2, 6);
    check_dir("dir_run");
    check("dir_run_en", {31'd0, run_en}, 32'd1);
    press(0, 6);
    // dir event lands one cycle after clr event, i.e. during ST_CLEAR
    btn_clr = 1'b1;
    tick(1);
    btn_dir = 1'b1;
    tick(6);
    btn_clr = 1'b0;
    btn_dir = 1'b0;
    tick(12);
    check_dir("dir_clear");
    check("dir_clear_state", {30'd0, state}, 32'd0);
    check("dir_clear_run_en", {31'd0, run_en}, 32'd0);

    // async reset mid-run, with a press held across reset
    press(0, 6);
    check("pre_rst_run_en", {31'd0, run_en}, 32'd1);
    btn_run = 1'b1;
    tick(2);
    #2 rst = 1'b1;
    #1;
    check("arst_run_en", {31'd0, run_en}, 32'd0);
    check("arst_clr", {31'd0, clr}, 32'd0);
    check("arst_dir", {31'd0, dir_down}, 32'd0);
    check("arst_state", {30'd0, state}, 32'd0);
    tick(3);
    rst = 1'b0;
    tick(12);
    check("held_after_rst", {31'd0, run_en}, 32'd1);
    tog0 = run_tog;
    btn_run = 1'b0;
    tick(12);
    check("release_no_ev", run_tog - tog0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
